// File: rtl/reg_writeback_queue.sv
// In-order write-back queue in front of the 16x32 register file; drains one entry per SETUP/STROBE pair.
// Optional WBQ_PENDING_MASK_EN adds a combinational pending_mask output listing registers with writes outstanding.
module reg_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      enable_write,
  output logic [ADDR_W-1:0]         RW,
  output logic [DATA_W-1:0]         BusW,
  output logic [$clog2(DEPTH):0]    count,
`ifdef WBQ_PENDING_MASK_EN
  output logic [(2**ADDR_W)-1:0]    pending_mask,
`endif
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fifo_rd   [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, alu_slot;
  logic [CNT_W-1:0]   free_slots;
  logic               acc_mem, acc_alu, pop;
  logic               en_d;
  logic [ADDR_W-1:0]  rw_d;
  logic [DATA_W-1:0]  busw_d;

  // Readies look only at the registered count; a same-cycle pop does not help.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign mem_ready  = (free_slots != '0);
  assign alu_ready  = mem_valid ? (free_slots >= CNT_W'(2)) : (free_slots != '0);
  assign acc_mem    = mem_valid & mem_ready;
  assign acc_alu    = alu_valid & alu_ready;
  assign alu_slot   = wr_ptr + PTR_W'(acc_mem);
  assign empty      = (count == '0) && (state_q == IDLE);

  // Storage: mem entry lands ahead of the alu entry when both are taken.
  always_ff @(posedge clock) begin
    if (acc_mem) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
    if (acc_alu) begin
      fifo_rd[alu_slot]   <= alu_rd;
      fifo_data[alu_slot] <= alu_data;
    end
  end

  // Drain FSM: RW/BusW load only when entering SETUP, so they never move under a high strobe.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rw_d    = RW;
    busw_d  = BusW;
    case (state_q)
      IDLE, STROBE: begin
        if (count != '0) begin
          rw_d    = fifo_rd[rd_ptr];
          busw_d  = fifo_data[rd_ptr];
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = STROBE;
      default: state_d = IDLE;
    endcase
    en_d = (state_d == STROBE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      enable_write <= 1'b0;
      RW           <= '0;
      BusW         <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      state_q      <= state_d;
      enable_write <= en_d;
      RW           <= rw_d;
      BusW         <= busw_d;
      count        <= count + CNT_W'(acc_mem) + CNT_W'(acc_alu) - CNT_W'(pop);
      wr_ptr       <= wr_ptr + PTR_W'(acc_mem) + PTR_W'(acc_alu);
      rd_ptr       <= rd_ptr + PTR_W'(pop);
    end
  end

`ifdef WBQ_PENDING_MASK_EN
  // Registers with a queued entry or a write currently being issued.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) pending_mask[fifo_rd[rd_ptr + PTR_W'(i)]] = 1'b1;
    end
    if (state_q != IDLE) pending_mask[RW] = 1'b1;
  end
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side companion to the 16x32 register file: collects destination-register results from the ALU and memory stages, buffers them in order, and drives the file's write port.
- The file writes on the rising edge of its write-enable, so this block emits a clean low-high-low strobe per write, with RW/BusW held stable around the edge.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DATA_W, 32, result data width
ADDR_W, 4, register index width (16 registers)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle if alu_valid
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted this cycle if mem_valid
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load result
enable_write  out  1  register-file write strobe; file writes on its rising edge
RW  out  ADDR_W  register index being written
BusW  out  DATA_W  data being written
count  out  clog2(DEPTH)+1  occupied FIFO entries
empty  out  1  count==0 and FSM in IDLE

Behaviour:
- Interface: one clock, `clock`; asynchronous active-low reset, `reset_n`.
- Reset (asynchronous, immediate): enable_write=0, RW=0, BusW=0, count=0, FIFO pointers=0, FSM=IDLE, empty=1. Any in-flight write is abandoned; enable_write drops immediately.
- Readies are combinational from registered count only. They never depend on the same port's valid, and they ignore the pop occurring this cycle.
  - mem_ready = (DEPTH-count) >= 1.
  - alu_ready = (DEPTH-count) >= (mem_valid ? 2 : 1).
  - Memory has priority.
- Both accepted in the same cycle: the mem entry is enqueued ahead of the alu entry.
- Enqueue order is preserved to the register file.
- count_next = count + accepted_mem + accepted_alu - pop. Never exceeds DEPTH and never underflows.
- Read/write pointers wrap modulo DEPTH.
- Drain FSM:
  - IDLE: enable_write=0. If count>0: load head into RW/BusW, pop, go to SETUP.
  - SETUP: enable_write=0; RW/BusW held. Next state is STROBE.
  - STROBE: enable_write=1; RW/BusW held. If count>0 (registered), load next head and pop, go to SETUP; else go to IDLE.
- enable_write, RW and BusW are registered outputs.
- Latency: an entry accepted at edge N, into an empty queue with FSM in IDLE, gives:
  - RW/BusW valid after edge N+1.
  - enable_write high after edge N+2, low after edge N+3.
- Steady-state drain rate is one write per 2 cycles.
- RW/BusW change only on the IDLE->SETUP and STROBE->SETUP transitions, never while enable_write=1. This gives one full cycle of setup before the strobe edge and one cycle of hold after it.
- Writes to register 0 are queued and issued like any other register.
- Simultaneous enqueue and pop when full: the pop frees a slot only for the next cycle, because ready used the registered count.

Optional Feature:
- Macro: WBQ_PENDING_MASK_EN.
- Defined: adds output port pending_mask [15:0] (combinational).
  - Bit r=1 if any valid FIFO entry has rd==r, or the FSM is in SETUP/STROBE with RW==r.
  - Decode stages use it to stall reads of registers with writes still queued.
  - Reset value 0.
- Undefined: port absent, no mask logic; all other behaviour identical.

Test Plan:
- Reset check: hold reset_n=0, then release → enable_write=0, count=0, empty=1, alu_ready=1, mem_ready=1.
- Single ALU write, alu_rd=5, alu_data=0xDEADBEEF, one cycle → RW=5 and BusW=0xDEADBEEF one cycle later; exactly one enable_write pulse two cycles after accept; empty=1 after the pulse.
- Ordering, same cycle: mem(rd=3, 0x11111111) and alu(rd=4, 0x22222222) → strobes in order rd=3 then rd=4; strobes 2 cycles apart, with enable_write low in between.
- Full queue: stream 6 ALU results back-to-back at DEPTH=4 → alu_ready drops when count=4; no entry lost or duplicated; all 6 writes appear in order with distinct strobes.
- Priority with 1 free slot: count=3, mem_valid=1 and alu_valid=1 → mem_ready=1, alu_ready=0; only the mem entry is enqueued.
- Reset mid-write: assert reset_n=0 while enable_write=1 → enable_write=0 immediately; after release, count=0 and no further strobes. With WBQ_PENDING_MASK_EN defined, pending_mask=0.
